// File: rtl/ft_err_monitor.sv
// ft_err_monitor: per-replica error supervisor for a triple-redundant voter.
// Each replica's disagreement events move it through OK -> SUSPECT -> FAULTY
// and drive resynchronisation requests. Events also feed a single-entry
// report register that supports one record per cycle.
// Optional feature: define FT_ERR_MON_UNCORR_EN to report uncorrectable
// (no-majority) errors and to drive fatal_o. When it is undefined,
// err_uncorr_i is ignored and fatal_o stays 0.
module ft_err_monitor #(
  parameter int N_S    = 2,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4,
  parameter int QUIET  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_S-1:0]   err_detected_1_i,
  input  logic [N_S-1:0]   err_detected_2_i,
  input  logic [N_S-1:0]   err_detected_3_i,
  input  logic [N_S-1:0]   err_uncorr_i,
  input  logic             clear_i,
  output logic             rpt_valid_o,
  input  logic             rpt_ready_i,
  output logic [1:0]       rpt_kind_o,
  output logic [1:0]       rpt_replica_o,
  output logic [2:0]       resync_req_o,
  input  logic [2:0]       resync_ack_i,
  output logic [2:0]       replica_faulty_o,
  output logic             overflow_o,
  output logic             fatal_o
);

  localparam int QW = (QUIET > 1) ? $clog2(QUIET + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH);
  localparam logic [QW-1:0]    QUIET_ZERO = {QW{1'b0}};
  localparam logic [QW-1:0]    QUIET_ONE  = QW'(1);
  localparam logic [QW-1:0]    QUIET_LAST = QW'(QUIET - 1);

  localparam logic [1:0] KIND_ERR    = 2'd0;
  localparam logic [1:0] KIND_FAULTY = 2'd1;
  localparam logic [1:0] KIND_UNCORR = 2'd2;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTY  = 2'd2
  } state_t;

  state_t           state_r [3];
  state_t           state_s [3];
  logic [CNT_W-1:0] cnt_r   [3];
  logic [CNT_W-1:0] cnt_s   [3];
  logic [QW-1:0]    quiet_r [3];
  logic [QW-1:0]    quiet_s [3];

  logic [2:0] event_s;
  logic [2:0] to_faulty_s;
  logic [2:0] err_rec_s;
  logic       uncorr_s;
  logic [6:0] cand_s;
  logic       have_s;
  logic       multi_s;
  logic       can_load_s;
  logic       load_s;
  logic       ovf_set_s;
  logic [1:0] sel_kind_s;
  logic [1:0] sel_rep_s;

  logic       rpt_valid_r;
  logic [1:0] rpt_kind_r;
  logic [1:0] rpt_rep_r;
  logic [2:0] faulty_r;
  logic       overflow_r;
  logic       fatal_r;

  // Saturating increment of an error counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Replica number (1..3) of the lowest set bit, 0 when none is set.
  function automatic logic [1:0] first_rep(input logic [2:0] v);
    if (v[0]) begin
      first_rep = 2'd1;
    end else if (v[1]) begin
      first_rep = 2'd2;
    end else if (v[2]) begin
      first_rep = 2'd3;
    end else begin
      first_rep = 2'd0;
    end
  endfunction

  // Several group bits from one replica in one cycle are a single event.
  assign event_s = {|err_detected_3_i, |err_detected_2_i, |err_detected_1_i};

`ifdef FT_ERR_MON_UNCORR_EN
  assign uncorr_s = |err_uncorr_i;
`else
  logic unused_uncorr_s;
  assign unused_uncorr_s = |err_uncorr_i;
  assign uncorr_s        = 1'b0;
`endif

  // Per-replica next state; the event that crosses THRESH reports as a faulty
  // transition rather than as a plain error, and events while FAULTY are dropped.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      state_s[k]     = state_r[k];
      cnt_s[k]       = cnt_r[k];
      quiet_s[k]     = quiet_r[k];
      to_faulty_s[k] = 1'b0;
      err_rec_s[k]   = 1'b0;
      case (state_r[k])
        ST_OK, ST_SUSPECT: begin
          if (event_s[k]) begin
            cnt_s[k]   = sat_inc(cnt_r[k]);
            quiet_s[k] = QUIET_ZERO;
            if (sat_inc(cnt_r[k]) >= THRESH_C) begin
              state_s[k]     = ST_FAULTY;
              to_faulty_s[k] = 1'b1;
            end else begin
              state_s[k]   = ST_SUSPECT;
              err_rec_s[k] = 1'b1;
            end
          end else if (state_r[k] == ST_SUSPECT) begin
            if (quiet_r[k] == QUIET_LAST) begin
              state_s[k] = ST_OK;
              cnt_s[k]   = CNT_ZERO;
              quiet_s[k] = QUIET_ZERO;
            end else begin
              quiet_s[k] = quiet_r[k] + QUIET_ONE;
            end
          end else begin
            state_s[k] = ST_OK;
          end
        end
        ST_FAULTY: begin
          if (resync_ack_i[k]) begin
            state_s[k] = ST_OK;
            cnt_s[k]   = CNT_ZERO;
            quiet_s[k] = QUIET_ZERO;
          end else begin
            state_s[k] = ST_FAULTY;
          end
        end
        default: begin
          state_s[k] = ST_OK;
          cnt_s[k]   = CNT_ZERO;
          quiet_s[k] = QUIET_ZERO;
        end
      endcase
    end
  end

  // Pick the highest-priority record; any other candidate counts as dropped.
  always_comb begin
    sel_kind_s = KIND_ERR;
    sel_rep_s  = 2'd0;
    if (uncorr_s) begin
      sel_kind_s = KIND_UNCORR;
      sel_rep_s  = 2'd0;
    end else if (|to_faulty_s) begin
      sel_kind_s = KIND_FAULTY;
      sel_rep_s  = first_rep(to_faulty_s);
    end else begin
      sel_kind_s = KIND_ERR;
      sel_rep_s  = first_rep(err_rec_s);
    end
  end

  assign cand_s     = {err_rec_s, to_faulty_s, uncorr_s};
  assign have_s     = |cand_s;
  assign multi_s    = (cand_s & (cand_s - 7'd1)) != 7'd0;
  assign can_load_s = ~rpt_valid_r | rpt_ready_i;
  assign load_s     = have_s & can_load_s;
  assign ovf_set_s  = multi_s | (have_s & ~can_load_s);

  // State, counters, report register and sticky flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 3; k++) begin
        state_r[k] <= ST_OK;
        cnt_r[k]   <= CNT_ZERO;
        quiet_r[k] <= QUIET_ZERO;
      end
      faulty_r    <= 3'b000;
      rpt_valid_r <= 1'b0;
      rpt_kind_r  <= 2'd0;
      rpt_rep_r   <= 2'd0;
      overflow_r  <= 1'b0;
      fatal_r     <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_r[k]  <= state_s[k];
        cnt_r[k]    <= cnt_s[k];
        quiet_r[k]  <= quiet_s[k];
        faulty_r[k] <= (state_s[k] == ST_FAULTY);
      end
      if (load_s) begin
        rpt_valid_r <= 1'b1;
        rpt_kind_r  <= sel_kind_s;
        rpt_rep_r   <= sel_rep_s;
      end else if (rpt_ready_i) begin
        rpt_valid_r <= 1'b0;
      end else begin
        rpt_valid_r <= rpt_valid_r;
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clear_i) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (uncorr_s) begin
        fatal_r <= 1'b1;
      end else if (clear_i) begin
        fatal_r <= 1'b0;
      end else begin
        fatal_r <= fatal_r;
      end
    end
  end

  assign rpt_valid_o      = rpt_valid_r;
  assign rpt_kind_o       = rpt_kind_r;
  assign rpt_replica_o    = rpt_rep_r;
  assign replica_faulty_o = faulty_r;
  assign resync_req_o     = faulty_r;
  assign overflow_o       = overflow_r;
  assign fatal_o          = fatal_r;

endmodule

// File: tb/tb_ft_err_monitor.sv
// tb_ft_err_monitor: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the replica supervisors and the report path.
module tb_ft_err_monitor;

  localparam int THRESH = 4;
  localparam int QUIET  = 16;
  localparam int CMAX   = 255;

  logic       clk;
  logic       rst;
  logic [1:0] det [3];
  logic [1:0] uncorr;
  logic       clear;
  logic       ready;
  logic [2:0] ack;

  logic       rpt_valid_o;
  logic [1:0] rpt_kind_o;
  logic [1:0] rpt_replica_o;
  logic [2:0] resync_req_o;
  logic [2:0] replica_faulty_o;
  logic       overflow_o;
  logic       fatal_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = OK, 1 = SUSPECT, 2 = FAULTY
  int m_mode [3];
  int m_cnt  [3];
  int m_idle [3];
  bit m_valid;
  int m_kind;
  int m_rep;
  bit m_ovf;
  bit m_fatal;

  ft_err_monitor #(.N_S(2), .CNT_W(8), .THRESH(THRESH), .QUIET(QUIET)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .err_detected_1_i (det[0]),
    .err_detected_2_i (det[1]),
    .err_detected_3_i (det[2]),
    .err_uncorr_i     (uncorr),
    .clear_i          (clear),
    .rpt_valid_o      (rpt_valid_o),
    .rpt_ready_i      (ready),
    .rpt_kind_o       (rpt_kind_o),
    .rpt_replica_o    (rpt_replica_o),
    .resync_req_o     (resync_req_o),
    .resync_ack_i     (ack),
    .replica_faulty_o (replica_faulty_o),
    .overflow_o       (overflow_o),
    .fatal_o          (fatal_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int ck[$];
    int cr[$];
    int fq[$];
    int eq[$];
    bit can;
    bit fset;
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        m_mode[r] = 0; m_cnt[r] = 0; m_idle[r] = 0;
      end
      m_valid = 0; m_kind = 0; m_rep = 0; m_ovf = 0; m_fatal = 0;
      return;
    end
    can  = !m_valid || ready;
    fset = 0;
`ifdef FT_ERR_MON_UNCORR_EN
    if (uncorr != 2'b00) begin
      ck.push_back(2); cr.push_back(0); fset = 1;
    end
`endif
    for (int r = 0; r < 3; r++) begin
      if (m_mode[r] == 2) begin
        if (ack[r]) begin
          m_mode[r] = 0; m_cnt[r] = 0; m_idle[r] = 0;
        end
      end else if (det[r] != 2'b00) begin
        m_cnt[r]  = (m_cnt[r] < CMAX) ? m_cnt[r] + 1 : CMAX;
        m_idle[r] = 0;
        if (m_cnt[r] >= THRESH) begin
          m_mode[r] = 2; fq.push_back(r + 1);
        end else begin
          m_mode[r] = 1; eq.push_back(r + 1);
        end
      end else if (m_mode[r] == 1) begin
        m_idle[r]++;
        if (m_idle[r] == QUIET) begin
          m_mode[r] = 0; m_cnt[r] = 0; m_idle[r] = 0;
        end
      end
    end
    foreach (fq[i]) begin ck.push_back(1); cr.push_back(fq[i]); end
    foreach (eq[i]) begin ck.push_back(0); cr.push_back(eq[i]); end
    if (ck.size() > 0 && can) begin
      m_valid = 1; m_kind = ck[0]; m_rep = cr[0];
    end else if (ready) begin
      m_valid = 0;
    end
    if (ck.size() > 1 || (ck.size() > 0 && !can)) m_ovf = 1;
    else if (clear) m_ovf = 0;
    if (fset) m_fatal = 1;
    else if (clear) m_fatal = 0;
  endtask

  task automatic check_all();
    logic [2:0] ef;
    for (int r = 0; r < 3; r++) ef[r] = (m_mode[r] == 2);
    chk("valid",    rpt_valid_o,      m_valid);
    chk("kind",     rpt_kind_o,       m_kind);
    chk("replica",  rpt_replica_o,    m_rep);
    chk("faulty",   replica_faulty_o, ef);
    chk("resync",   resync_req_o,     ef);
    chk("overflow", overflow_o,       m_ovf);
    chk("fatal",    fatal_o,          m_fatal);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    for (int r = 0; r < 3; r++) det[r] = 2'b00;
    uncorr = 2'b00; clear = 1'b0; ack = 3'b000; ready = 1'b1; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Stimulus sequence.
  initial begin
    int p;
    idle_inputs();
    do_reset();
    chk("rst_valid",  rpt_valid_o, 1'b0);
    chk("rst_faulty", replica_faulty_o, 3'b000);

    // Single event on replica 2.
    det[1] = 2'b01; step(); idle_inputs();
    chk("ev2_valid", rpt_valid_o, 1'b1);
    chk("ev2_kind",  rpt_kind_o, 2'd0);
    chk("ev2_rep",   rpt_replica_o, 2'd2);
    step();
    chk("ev2_drain", rpt_valid_o, 1'b0);
    do_reset();

    // Four events on replica 1 -> faulty, then resync ack.
    for (int i = 0; i < 4; i++) begin det[0] = 2'b11; step(); end
    idle_inputs();
    chk("th_faulty", replica_faulty_o, 3'b001);
    chk("th_resync", resync_req_o, 3'b001);
    chk("th_kind",   rpt_kind_o, 2'd1);
    chk("th_rep",    rpt_replica_o, 2'd1);
    det[0] = 2'b01; step(); idle_inputs();
    chk("fty_ignore", replica_faulty_o, 3'b001);
    ack = 3'b001; step(); idle_inputs();
    chk("ack_faulty", replica_faulty_o, 3'b000);
    chk("ack_resync", resync_req_o, 3'b000);
    do_reset();

    // Replica 3 quiet-period recovery: 16 idle cycles clear the count.
    det[2] = 2'b10; step(); idle_inputs();
    for (int i = 0; i < QUIET; i++) step();
    for (int i = 0; i < 3; i++) begin det[2] = 2'b01; step(); end
    idle_inputs();
    chk("quiet_ok", replica_faulty_o, 3'b000);
    do_reset();
    // Event at idle cycle 15 keeps replica 3 suspect.
    det[2] = 2'b10; step(); idle_inputs();
    for (int i = 0; i < QUIET - 2; i++) step();
    det[2] = 2'b01; step(); idle_inputs();
    for (int i = 0; i < 2; i++) begin det[2] = 2'b01; step(); end
    idle_inputs();
    chk("quiet_susp", replica_faulty_o, 3'b100);
    do_reset();

    // Simultaneous events on 1 and 3 with consumer stalled.
    ready = 1'b0; det[0] = 2'b01; det[2] = 2'b01; step();
    idle_inputs(); ready = 1'b0;
    chk("ovf_rep", rpt_replica_o, 2'd1);
    chk("ovf_set", overflow_o, 1'b1);
    clear = 1'b1; step(); idle_inputs();
    chk("ovf_clr", overflow_o, 1'b0);
    do_reset();

    // Uncorrectable together with a replica 2 event.
    uncorr = 2'b10; det[1] = 2'b01; step(); idle_inputs();
`ifdef FT_ERR_MON_UNCORR_EN
    chk("unc_kind",  rpt_kind_o, 2'd2);
    chk("unc_rep",   rpt_replica_o, 2'd0);
    chk("unc_fatal", fatal_o, 1'b1);
    chk("unc_ovf",   overflow_o, 1'b1);
`else
    chk("unc_kind",  rpt_kind_o, 2'd0);
    chk("unc_rep",   rpt_replica_o, 2'd2);
    chk("unc_fatal", fatal_o, 1'b0);
`endif
    do_reset();

    // Reset while a record is pending and replica 1 is faulty.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin det[0] = 2'b01; step(); end
    idle_inputs(); ready = 1'b0;
    chk("pre_valid",  rpt_valid_o, 1'b1);
    chk("pre_faulty", replica_faulty_o, 3'b001);
    rst = 1'b1; det[1] = 2'b11; step();
    chk("mid_valid",  rpt_valid_o, 1'b0);
    chk("mid_kind",   rpt_kind_o, 2'd0);
    chk("mid_rep",    rpt_replica_o, 2'd0);
    chk("mid_faulty", replica_faulty_o, 3'b000);
    chk("mid_resync", resync_req_o, 3'b000);
    chk("mid_ovf",    overflow_o, 1'b0);
    do_reset();

    // Randomized traffic in phases of differing event density.
    for (int ph = 0; ph < 12; ph++) begin
      p = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 10 : 30);
      for (int c = 0; c < 200; c++) begin
        for (int r = 0; r < 3; r++)
          det[r] = ($urandom_range(99) < p) ? 2'($urandom_range(3, 1)) : 2'b00;
        uncorr = ($urandom_range(99) < 3) ? 2'($urandom_range(3, 1)) : 2'b00;
        ready  = ($urandom_range(99) < 70);
        clear  = ($urandom_range(99) < 5);
        ack    = 3'($urandom_range(7));
        if ($urandom_range(99) >= 15) ack = 3'b000;
        rst    = ($urandom_range(999) < 3);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
